// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text_writer terminal block: control-character
// codes, the writer FSM states, the cursor command set and a width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package text_pkg;

  // Control and reference character codes understood by the writer.
  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Writer FSM states. LINECLR is only reachable when the line-clear
  // feature is compiled in.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    LINECLR = 2'd2
  } state_e;

  // Commands issued by the writer to the cursor, at most one per cycle.
  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_HOME    = 3'd1,
    CMD_CR      = 3'd2,
    CMD_LF      = 3'd3,
    CMD_BS      = 3'd4,
    CMD_ADVANCE = 3'd5
  } cursor_cmd_e;

  // Bits needed to hold 0..value-1. Never returns 0 so that a degenerate
  // one-column or one-row screen still yields a legal vector width.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/text_cursor.sv
// -----------------------------------------------------------------------------
// text_cursor
// Cursor position tracker for text_writer. Owns the column, the row and the
// row base address (row * COLS, maintained incrementally so no multiplier is
// needed), and applies one cursor command per cycle with wrap-around.
//
// Ports:
//   clk       in   clock
//   resetn    in   asynchronous active-low reset (cursor to 0/0)
//   cmd       in   cursor command for this cycle (CMD_NONE = hold)
//   col       out  current column, 0..COLS-1
//   row       out  current row, 0..ROWS-1
//   row_base  out  text RAM address of column 0 of the current row
// -----------------------------------------------------------------------------
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12,
  parameter int COL_W      = clog2(COLS),
  parameter int ROW_W      = clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  cursor_cmd_e           cmd,
  output logic [COL_W-1:0]      col,
  output logic [ROW_W-1:0]      row,
  output logic [ADDR_WIDTH-1:0] row_base
);

  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(COLS);

  logic [ROW_W-1:0]      row_next;
  logic [ADDR_WIDTH-1:0] base_next;

  // Position of the following row. There is no scrolling: the bottom row
  // wraps to the top and the base address returns to 0 with it.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here the first two lines) so no latch is inferred.
  always_comb begin
    row_next  = row + ROW_W'(1);
    base_next = row_base + ROW_STEP;
    if (row == LAST_ROW) begin
      row_next  = '0;
      base_next = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (cmd)
        CMD_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end
        CMD_CR: col <= '0;
        CMD_LF: begin
          col      <= '0;
          row      <= row_next;
          row_base <= base_next;
        end
        CMD_BS: begin
          if (col != '0) col <= col - COL_W'(1);
        end
        CMD_ADVANCE: begin
          if (col == LAST_COL) begin
            col      <= '0;
            row      <= row_next;
            row_base <= base_next;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
// Terminal-style writer for the character RAM read by the video scanout.
// Accepts bytes over a valid/ready handshake, interprets CR, LF, BS and FF,
// writes printable codes (0x20..0xFF) at the cursor and sweeps the whole
// screen to BLANK after reset, on FF and on the clear request.
//
// Optional feature (compile-time macro TEXT_WRITER_LINECLR_EN): whenever the
// cursor enters a new row (LF or wrap after the last column) the new row is
// blanked, one cell per cycle, before further bytes are accepted.
//
// Ports:
//   clk         in   clock
//   resetn      in   asynchronous active-low reset
//   in_valid    in   in_char holds a byte
//   in_ready    out  a byte is accepted this cycle if in_valid is high
//   in_char     in   byte to interpret
//   clear       in   level request for a full-screen clear
//   busy        out  full-screen clear sweep in progress
//   write_en    out  text RAM write strobe (one cycle per cell)
//   waddr       out  text RAM write address
//   wdata       out  text RAM write data (glyph code)
//   cursor_col  out  current cursor column
//   cursor_row  out  current cursor row
// -----------------------------------------------------------------------------
module text_writer
  import text_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_WIDTH = 12,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] BLANK      = CHAR_SPACE
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_char,
  input  logic                     clear,
  output logic                     busy,
  output logic                     write_en,
  output logic [ADDR_WIDTH-1:0]    waddr,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [clog2(COLS)-1:0]   cursor_col,
  output logic [clog2(ROWS)-1:0]   cursor_row
);

  localparam int                    COL_W      = clog2(COLS);
  localparam int                    CELLS      = COLS * ROWS;
  localparam logic [ADDR_WIDTH-1:0] LAST_CELL  = ADDR_WIDTH'(CELLS - 1);
  localparam logic [DATA_WIDTH-1:0] BLANK_CODE = DATA_WIDTH'(BLANK);

  // The screen must fit in the text RAM address space.
  generate
    if (CELLS > 2 ** ADDR_WIDTH) begin : g_size_check
      $error("text_writer: COLS*ROWS exceeds the text RAM address space");
    end
  endgenerate

  state_e                state;
  logic [ADDR_WIDTH-1:0] sweep;       // cell index within the running sweep
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] cur_addr;
  cursor_cmd_e           cmd;
  logic                  clear_req;
  logic                  accept;

`ifdef TEXT_WRITER_LINECLR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_LINE_CELL = ADDR_WIDTH'(COLS - 1);

  logic clear_pend;  // clear seen during a line clear, served afterwards
  logic new_row;

  assign clear_req = clear | clear_pend;
  assign new_row   = (cmd == CMD_LF) ||
                     ((cmd == CMD_ADVANCE) && (cursor_col == COL_W'(COLS - 1)));
`else
  assign clear_req = clear;
`endif

  // A clear request wins over a byte offered in the same cycle: ready drops,
  // so the byte simply stays pending at the source.
  assign in_ready = (state == IDLE) && !clear_req;
  assign accept   = in_valid && in_ready;
  assign cur_addr = row_base + ADDR_WIDTH'(cursor_col);

  // Cursor command for this cycle, decoded from the accepted byte.
  always_comb begin
    cmd = CMD_NONE;
    if ((state == IDLE) && clear_req) begin
      cmd = CMD_HOME;
    end else if (accept) begin
      case (in_char)
        CHAR_CR: cmd = CMD_CR;
        CHAR_LF: cmd = CMD_LF;
        CHAR_BS: cmd = CMD_BS;
        CHAR_FF: cmd = CMD_HOME;
        default: if (in_char >= CHAR_SPACE) cmd = CMD_ADVANCE;
      endcase
    end
  end

  text_cursor #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cursor (
    .clk      (clk),
    .resetn   (resetn),
    .cmd      (cmd),
    .col      (cursor_col),
    .row      (cursor_row),
    .row_base (row_base)
  );

  // Writer FSM and registered RAM write port. Reset lands in CLEAR with the
  // sweep counter at 0, so the power-on screen clear needs no extra trigger.
  // NOTE: the text RAM itself has no reset; its contents only become defined
  // through the sweep, which is why reset always restarts it from cell 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= CLEAR;
      sweep    <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      wdata    <= BLANK_CODE;
      busy     <= 1'b1;
`ifdef TEXT_WRITER_LINECLR_EN
      clear_pend <= 1'b0;
`endif
    end else begin
      write_en <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (clear_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            sweep <= '0;
`ifdef TEXT_WRITER_LINECLR_EN
            clear_pend <= 1'b0;
`endif
          end else if (accept) begin
            if (in_char == CHAR_FF) begin
              state <= CLEAR;
              busy  <= 1'b1;
              sweep <= '0;
            end else if (in_char == CHAR_BS) begin
              // Blank the cell the cursor steps back onto.
              if (cursor_col != '0) begin
                write_en <= 1'b1;
                waddr    <= cur_addr - ADDR_WIDTH'(1);
                wdata    <= BLANK_CODE;
              end
            end else if (in_char >= CHAR_SPACE) begin
              write_en <= 1'b1;
              waddr    <= cur_addr;
              wdata    <= DATA_WIDTH'(in_char);
            end
`ifdef TEXT_WRITER_LINECLR_EN
            // row_base already points at the new row when LINECLR starts.
            if (new_row) begin
              state <= LINECLR;
              sweep <= '0;
            end
`endif
          end
        end

        CLEAR: begin
          write_en <= 1'b1;
          waddr    <= sweep;
          wdata    <= BLANK_CODE;
          // busy stays high through the last write and drops from IDLE.
          if (sweep == LAST_CELL) begin
            state <= IDLE;
          end else begin
            sweep <= sweep + ADDR_WIDTH'(1);
          end
        end

`ifdef TEXT_WRITER_LINECLR_EN
        LINECLR: begin
          write_en <= 1'b1;
          waddr    <= row_base + sweep;
          wdata    <= BLANK_CODE;
          if (clear) clear_pend <= 1'b1;
          if (sweep == LAST_LINE_CELL) begin
            state <= IDLE;
          end else begin
            sweep <= sweep + ADDR_WIDTH'(1);
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
